// File: rtl/tree_mul_pkg.sv
// Shared constants and helpers for the pipelined carry-save tree multiplier:
// parameter legality bounds and the split of reduction rows across stages.
package tree_mul_pkg;

    localparam int unsigned WIDTH_MIN  = 4;
    localparam int unsigned WIDTH_MAX  = 64;
    localparam int unsigned STAGES_MIN = 1;
    localparam int unsigned STAGES_MAX = 6;

    // WIDTH partial products need WIDTH-2 rows of 3:2 compressors; the first
    // (rows % stages) stages take one extra row.
    function automatic int unsigned rows_per_stage(input int unsigned width,
                                                   input int unsigned stages,
                                                   input int unsigned st);
        int unsigned rows;
        int unsigned base;
        int unsigned rem;
        rows = width - 2;
        base = rows / stages;
        rem  = rows % stages;
        return base + ((st < rem) ? 1 : 0);
    endfunction

    function automatic int unsigned first_row(input int unsigned width,
                                              input int unsigned stages,
                                              input int unsigned st);
        int unsigned acc;
        acc = 0;
        for (int unsigned k = 0; k < st; k++) begin
            acc += rows_per_stage(width, stages, k);
        end
        return acc;
    endfunction

endpackage

// File: rtl/pipelined_tree_mul_csa_3to2.sv
// 3:2 carry-save compressor row: bitwise sum and majority carry shifted left.
module csa_3to2
    import tree_mul_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] i_x,
    input  logic [W-1:0] i_y,
    input  logic [W-1:0] i_z,
    output logic [W-1:0] o_sum,
    output logic [W-1:0] o_carry
);

    assign o_sum   = i_x ^ i_y ^ i_z;
    assign o_carry = ((i_x & i_y) | (i_x & i_z) | (i_y & i_z)) << 1;

endmodule

// File: rtl/pipelined_tree_mul.sv
// Pipelined carry-save multiplier with valid/ready flow control.
// Define TREE_MUL_SIGNED_SEL_EN to add the per-operation is_signed input.
module pipelined_tree_mul
    import tree_mul_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
`ifdef TREE_MUL_SIGNED_SEL_EN
    input  logic                 is_signed,
`endif
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int unsigned PW = 2 * WIDTH;

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX ||
        STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : gen_param_err
        $error("pipelined_tree_mul: WIDTH or STAGES out of range");
    end

    // The MSB row of a signed multiplier carries negative weight: it is
    // inverted here and the +1 enters as carry-in of the final add.
    function automatic logic [PW-1:0] part_prod(input logic [WIDTH-1:0] av,
                                                input logic             bbit,
                                                input logic             sgn,
                                                input int unsigned      sh);
        logic [PW-1:0] a_ext;
        logic [PW-1:0] pp;
        a_ext = {{WIDTH{sgn & av[WIDTH-1]}}, av};
        pp    = bbit ? (a_ext << sh) : '0;
        if (sgn && bbit && (sh == WIDTH - 1)) begin
            pp = ~pp;
        end
        return pp;
    endfunction

    logic              w_sgn_in;
`ifdef TREE_MUL_SIGNED_SEL_EN
    assign w_sgn_in = is_signed;
`else
    assign w_sgn_in = 1'b1;
`endif

    // Per-stage inputs: index 0 comes from the ports, index st+1 from stage st.
    logic [WIDTH-1:0]  w_a   [STAGES];
    logic [WIDTH-1:0]  w_b   [STAGES];
    logic              w_sgn [STAGES];
    logic [PW-1:0]     w_s   [STAGES];
    logic [PW-1:0]     w_c   [STAGES];
    logic [STAGES:0]   w_v;
    logic [STAGES:0]   w_load;
    logic [PW-1:0]     r_result;

    assign w_a[0]   = a;
    assign w_b[0]   = b;
    assign w_sgn[0] = w_sgn_in;
    assign w_s[0]   = part_prod(a, b[0], w_sgn_in, 0);
    assign w_c[0]   = part_prod(a, b[1], w_sgn_in, 1);
    assign w_v[0]   = in_valid;

    assign w_load[STAGES] = out_ready;
    assign in_ready       = w_load[0];
    assign out_valid      = w_v[STAGES];
    assign result         = r_result;

    for (genvar st = 0; st < STAGES; st++) begin : gen_stage
        localparam int unsigned CNT   = rows_per_stage(WIDTH, STAGES, st);
        localparam int unsigned FIRST = first_row(WIDTH, STAGES, st);

        logic [PW-1:0] w_ch_s [CNT+1];
        logic [PW-1:0] w_ch_c [CNT+1];
        logic          r_vld;

        assign w_ch_s[0] = w_s[st];
        assign w_ch_c[0] = w_c[st];

        for (genvar j = 0; j < CNT; j++) begin : gen_row
            localparam int unsigned ROW = FIRST + j;
            logic [PW-1:0] w_pp;
            assign w_pp = part_prod(w_a[st], w_b[st][ROW+2], w_sgn[st], ROW + 2);
            csa_3to2 #(.W(PW)) u_csa (
                .i_x     (w_ch_s[j]),
                .i_y     (w_ch_c[j]),
                .i_z     (w_pp),
                .o_sum   (w_ch_s[j+1]),
                .o_carry (w_ch_c[j+1])
            );
        end

        // A stage may load when empty or when its contents move on this cycle.
        assign w_load[st] = !r_vld || w_load[st+1];
        assign w_v[st+1]  = r_vld;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_vld <= 1'b0;
            end else if (w_load[st]) begin
                r_vld <= w_v[st];
            end
        end

        if (st < STAGES - 1) begin : gen_mid
            logic [WIDTH-1:0] r_a;
            logic [WIDTH-1:0] r_b;
            logic             r_sgn;
            logic [PW-1:0]    r_s;
            logic [PW-1:0]    r_c;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_a   <= '0;
                    r_b   <= '0;
                    r_sgn <= 1'b0;
                    r_s   <= '0;
                    r_c   <= '0;
                end else if (w_load[st] && w_v[st]) begin
                    r_a   <= w_a[st];
                    r_b   <= w_b[st];
                    r_sgn <= w_sgn[st];
                    r_s   <= w_ch_s[CNT];
                    r_c   <= w_ch_c[CNT];
                end
            end

            assign w_a[st+1]   = r_a;
            assign w_b[st+1]   = r_b;
            assign w_sgn[st+1] = r_sgn;
            assign w_s[st+1]   = r_s;
            assign w_c[st+1]   = r_c;
        end else begin : gen_last
            logic          w_cin;
            logic [PW-1:0] w_sum;

            assign w_cin = w_sgn[st] & w_b[st][WIDTH-1];
            assign w_sum = w_ch_s[CNT] + w_ch_c[CNT] + PW'(w_cin);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_result <= '0;
                end else if (w_load[st] && w_v[st]) begin
                    r_result <= w_sum;
                end
            end
        end
    end

endmodule
